// File: rtl/xadc_drp_sampler_if.sv
// -----------------------------------------------------------------------------
// xadc_drp_sampler_if
// Bundles the XADC end-of-conversion side, the DRP read port and the
// raw_adc_data result of xadc_drp_sampler.
//
// Signal summary
//   eoc_in, channel_in           XADC -> sampler: conversion done + channel
//   daddr_out, den_out           sampler -> DRP: address and one-cycle enable
//   dwe_out, di_out              sampler -> DRP: write path, held at 0
//   do_in, drdy_in               DRP -> sampler: read data and its ready strobe
//   raw_adc_data, raw_adc_valid  sampler -> consumer: averaged word + strobe
//   drp_timeout_out              sampler -> monitor: read abandoned strobe
//
// Strobe semantics: every *_valid / den / drdy / eoc / timeout signal is a
// single-cycle pulse with no back-pressure. The receiver must take the
// associated data in the cycle the strobe is high; the sender never waits.
//
// Modports
//   master  the sampler itself
//   slave   the surrounding XADC/DRP/consumer environment
// -----------------------------------------------------------------------------
interface xadc_drp_sampler_if;
    logic        eoc_in;
    logic [4:0]  channel_in;
    logic [6:0]  daddr_out;
    logic        den_out;
    logic        dwe_out;
    logic [15:0] di_out;
    logic [15:0] do_in;
    logic        drdy_in;
    logic [15:0] raw_adc_data;
    logic        raw_adc_valid;
    logic        drp_timeout_out;

    modport master (
        input  eoc_in, channel_in, do_in, drdy_in,
        output daddr_out, den_out, dwe_out, di_out,
        output raw_adc_data, raw_adc_valid, drp_timeout_out
    );

    modport slave (
        output eoc_in, channel_in, do_in, drdy_in,
        input  daddr_out, den_out, dwe_out, di_out,
        input  raw_adc_data, raw_adc_valid, drp_timeout_out
    );
endinterface

// File: rtl/xadc_drp_sampler.sv
// -----------------------------------------------------------------------------
// xadc_drp_sampler
// On each XADC end-of-conversion, reads the converted channel over DRP and
// averages 2**AVG_LOG2 such reads into one 16-bit raw_adc_data word, strobed
// by raw_adc_valid for one cycle. A read that gets no drdy_in within
// TIMEOUT_CYC cycles is abandoned, the partial window is discarded and
// drp_timeout_out pulses.
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous, active-high
//   bus        xadc_drp_sampler_if.master (XADC, DRP and result signals)
//   fsm_state  current FSM state (IDLE=0, REQ=1, WAIT=2, OUT=3) for debug
// -----------------------------------------------------------------------------
module xadc_drp_sampler #(
    parameter int AVG_LOG2    = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    xadc_drp_sampler_if.master   bus,
    output logic [1:0]           fsm_state
);

    localparam int AW = 16 + AVG_LOG2;             // accumulator never overflows
    localparam int CW = AVG_LOG2 + 1;              // holds 2**AVG_LOG2 itself
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_OUT  = 2'd3;

    logic [1:0]    state;
    logic [AW-1:0] acc;
    logic [CW-1:0] cnt;
    logic [TW-1:0] tcnt;
    logic [6:0]    daddr;
    logic [15:0]   data;
    logic          valid;

    logic [CW-1:0] cnt_next;
    logic          window_full;
    logic          timeout_hit;

    assign cnt_next    = cnt + 1'b1;
    assign window_full = (cnt_next == CW'(2 ** AVG_LOG2));

    // tcnt is cleared in REQ, so it reads 0 in the first WAIT cycle; the
    // terminal cycle is therefore the TIMEOUT_CYC-th WAIT cycle, i.e.
    // TIMEOUT_CYC cycles after den_out. A drdy_in in that same cycle wins.
    assign timeout_hit = (state == ST_WAIT) && !bus.drdy_in &&
                         (tcnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            acc   <= '0;
            cnt   <= '0;
            tcnt  <= '0;
            daddr <= '0;
            data  <= '0;
            valid <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.eoc_in) begin
                        daddr <= {2'b00, bus.channel_in};
                        state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    tcnt  <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.drdy_in) begin
                        acc   <= acc + AW'(bus.do_in);
                        cnt   <= cnt_next;
                        state <= window_full ? ST_OUT : ST_IDLE;
                    end else if (timeout_hit) begin
                        acc   <= '0;
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                ST_OUT: begin
                    data  <= acc[AW-1:AVG_LOG2];
                    valid <= 1'b1;
                    acc   <= '0;
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.daddr_out       = daddr;
    assign bus.den_out         = (state == ST_REQ);
    assign bus.dwe_out         = 1'b0;
    assign bus.di_out          = 16'h0000;
    assign bus.raw_adc_data    = data;
    assign bus.raw_adc_valid   = valid;
    assign bus.drp_timeout_out = timeout_hit;
    assign fsm_state           = state;

endmodule

// File: tb/tb_xadc_drp_sampler.sv
// -----------------------------------------------------------------------------
// tb_xadc_drp_sampler
// Two samplers (AVG_LOG2=0 and AVG_LOG2=2, TIMEOUT_CYC=64) share the same
// XADC/DRP stimulus. The driver pushes expected den/valid/timeout events,
// tagged with the cycle they must appear in; one monitor process pops and
// compares them against both DUTs.
// -----------------------------------------------------------------------------
module tb_xadc_drp_sampler;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_q = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    // ---------------- shared stimulus ----------------
    logic        eoc = 1'b0;
    logic [4:0]  channel = '0;
    logic [15:0] do_data = '0;
    logic        drdy = 1'b0;
    bit          done = 1'b0;

    xadc_drp_sampler_if bus0 ();
    xadc_drp_sampler_if bus1 ();
    logic [1:0] st0, st1;

    assign bus0.eoc_in = eoc;  assign bus0.channel_in = channel;
    assign bus0.do_in  = do_data; assign bus0.drdy_in = drdy;
    assign bus1.eoc_in = eoc;  assign bus1.channel_in = channel;
    assign bus1.do_in  = do_data; assign bus1.drdy_in = drdy;

    xadc_drp_sampler #(.AVG_LOG2(0), .TIMEOUT_CYC(64)) dut0 (
        .clk(clk), .reset(rst), .bus(bus0.master), .fsm_state(st0));
    xadc_drp_sampler #(.AVG_LOG2(2), .TIMEOUT_CYC(64)) dut1 (
        .clk(clk), .reset(rst), .bus(bus1.master), .fsm_state(st1));

    logic        den_s[2], valid_s[2], to_s[2], dwe_s[2];
    logic [6:0]  daddr_s[2];
    logic [15:0] data_s[2], di_s[2];
    assign den_s[0] = bus0.den_out;  assign den_s[1] = bus1.den_out;
    assign valid_s[0] = bus0.raw_adc_valid; assign valid_s[1] = bus1.raw_adc_valid;
    assign to_s[0] = bus0.drp_timeout_out; assign to_s[1] = bus1.drp_timeout_out;
    assign dwe_s[0] = bus0.dwe_out;  assign dwe_s[1] = bus1.dwe_out;
    assign daddr_s[0] = bus0.daddr_out; assign daddr_s[1] = bus1.daddr_out;
    assign data_s[0] = bus0.raw_adc_data; assign data_s[1] = bus1.raw_adc_data;
    assign di_s[0] = bus0.di_out;    assign di_s[1] = bus1.di_out;

    // ---------------- scoreboard queues ----------------
    logic [38:0] den_q[$];   // {cycle, daddr}
    logic [31:0] to_q[$];    // cycle of expected timeout pulse
    logic [47:0] exp_q0[$];  // {cycle, data} for dut0
    logic [47:0] exp_q1[$];  // {cycle, data} for dut1

    // ---------------- reference model ----------------
    // Averaging window: sum the accepted reads; when the window is full the
    // result is the integer mean, due two cycles after the last read.
    longint win_sum[2];
    int     win_cnt[2];
    int     win_len[2] = '{1, 4};

    task automatic model_clear();
        for (int g = 0; g < 2; g++) begin
            win_sum[g] = 0;
            win_cnt[g] = 0;
        end
    endtask

    task automatic model_accept(input logic [15:0] val, input int c);
        logic [15:0] avg;
        for (int g = 0; g < 2; g++) begin
            win_sum[g] += longint'(val);
            win_cnt[g]++;
            if (win_cnt[g] == win_len[g]) begin
                avg = 16'(win_sum[g] / longint'(win_len[g]));
                if (g == 0) exp_q0.push_back({32'(c + 2), avg});
                else        exp_q1.push_back({32'(c + 2), avg});
                win_sum[g] = 0;
                win_cnt[g] = 0;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // d = 1..64: drdy d cycles after den (accepted); d = 0: no response;
    // d > 64: response arrives after the read was already abandoned.
    task automatic drive_read(input logic [4:0] ch, input int d,
                              input logic [15:0] val, input bit extra_eoc);
        int den_cyc;
        int wait_len;
        step();
        eoc = 1'b1;
        channel = ch;
        den_cyc = cyc + 1;
        den_q.push_back({32'(den_cyc), 2'b00, ch});
        if (d >= 1 && d <= 64) begin
            model_accept(val, den_cyc + d);
        end else begin
            to_q.push_back(32'(den_cyc + 64));
            model_clear();
        end
        step();
        eoc = 1'b0;
        wait_len = (d == 0) ? 66 : d;
        for (int k = 1; k <= wait_len; k++) begin
            step();
            if (extra_eoc && k == 1) begin
                eoc = 1'b1;
                channel = ch ^ 5'h1F;
            end else begin
                eoc = 1'b0;
            end
            if (k == d) begin
                drdy = 1'b1;
                do_data = val;
            end else begin
                drdy = 1'b0;
                do_data = 16'($urandom);
            end
        end
        step();
        drdy = 1'b0;
        eoc = 1'b0;
        repeat ($urandom_range(1, 3)) step();
    endtask

    task automatic apply_reset(input int n);
        rst = 1'b1;
        model_clear();
        repeat (n) step();
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] ramp[4];
        ramp[0] = 16'h1000; ramp[1] = 16'h2000; ramp[2] = 16'h3000; ramp[3] = 16'h4000;
        model_clear();
        repeat (3) step();
        rst = 1'b0;
        step();

        // single read, minimum latency
        drive_read(5'h03, 1, 16'hABCD, 1'b0);
        apply_reset(2);
        step();

        // ramp window
        for (int i = 0; i < 4; i++) drive_read(5'h07, 1, ramp[i], 1'b0);
        // full-scale window
        for (int i = 0; i < 4; i++) drive_read(5'h1F, $urandom_range(1, 5), 16'hFFFF, 1'b0);

        // partial window discarded by a timeout, then a fresh window
        drive_read(5'h02, 2, 16'h7777, 1'b0);
        drive_read(5'h02, 3, 16'h7777, 1'b0);
        drive_read(5'h02, 0, 16'h0000, 1'b0);
        for (int i = 0; i < 4; i++) drive_read(5'h10, 1, 16'h0400, 1'b0);

        // eoc re-asserted during WAIT is dropped
        for (int i = 0; i < 4; i++) drive_read(5'h05, 2, 16'h0123 + 16'(i), 1'b1);

        // drdy on the timeout terminal cycle wins; one cycle later it is too late
        drive_read(5'h08, 64, 16'h0F00, 1'b0);
        drive_read(5'h08, 65, 16'hDEAD, 1'b0);
        for (int i = 0; i < 4; i++) drive_read(5'h09, 64, 16'h0F00, 1'b0);

        // reset in WAIT, then a late drdy
        step();
        eoc = 1'b1;
        channel = 5'h0C;
        den_q.push_back({32'(cyc + 1), 7'h0C});
        step();
        eoc = 1'b0;
        repeat (3) step();
        apply_reset(2);
        drdy = 1'b1;
        do_data = 16'h5555;
        step();
        drdy = 1'b0;
        repeat (3) step();
        for (int i = 0; i < 4; i++) drive_read(5'h01, 1, 16'h0040, 1'b0);

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            drive_read(5'($urandom),
                       ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 8),
                       16'($urandom), ($urandom_range(0, 4) == 0));
        end

        repeat (5) step();
        done = 1'b1;
    end

    // ---------------- monitor ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] last_data[2] = '{16'h0, 16'h0};

    task automatic check(input string name, input int g,
                         input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h",
                     name, g, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [47:0] e;
        bit          have;
        if (done) begin
            check("exp_q0_drained", 0, exp_q0.size(), 0);
            check("exp_q1_drained", 1, exp_q1.size(), 0);
            check("den_q_drained", 0, den_q.size(), 0);
            check("to_q_drained", 0, to_q.size(), 0);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end else if (rst_q) begin
            for (int g = 0; g < 2; g++) begin
                check("reset_outputs", g,
                      {5'b0, daddr_s[g], data_s[g], den_s[g], valid_s[g], to_s[g], 1'b0},
                      32'h0);
                last_data[g] = 16'h0;
            end
        end else begin
            for (int g = 0; g < 2; g++) begin
                check("dwe_di_zero", g, {15'b0, dwe_s[g], di_s[g]}, 32'h0);
            end

            // den pulses
            if (den_q.size() > 0 && den_q[0][38:7] == 32'(cyc)) begin
                for (int g = 0; g < 2; g++) begin
                    check("den_pulse", g, 32'(den_s[g]), 32'd1);
                    check("daddr", g, 32'(daddr_s[g]), 32'(den_q[0][6:0]));
                end
                void'(den_q.pop_front());
            end else begin
                for (int g = 0; g < 2; g++)
                    if (den_s[g]) check("den_unexpected", g, 32'(den_s[g]), 32'd0);
            end

            // timeout pulses
            if (to_q.size() > 0 && to_q[0] == 32'(cyc)) begin
                for (int g = 0; g < 2; g++)
                    check("timeout_pulse", g, 32'(to_s[g]), 32'd1);
                void'(to_q.pop_front());
            end else begin
                for (int g = 0; g < 2; g++)
                    if (to_s[g]) check("timeout_unexpected", g, 32'(to_s[g]), 32'd0);
            end

            // averaged results and hold-between-updates
            for (int g = 0; g < 2; g++) begin
                have = 1'b0;
                e = '0;
                if (g == 0 && exp_q0.size() > 0 && exp_q0[0][47:16] <= 32'(cyc)) begin
                    have = 1'b1;
                    e = exp_q0.pop_front();
                end else if (g == 1 && exp_q1.size() > 0 && exp_q1[0][47:16] <= 32'(cyc)) begin
                    have = 1'b1;
                    e = exp_q1.pop_front();
                end
                if (have) begin
                    check("valid_cycle", g, {31'b0, valid_s[g]}, 32'd1);
                    check("raw_adc_data", g, 32'(data_s[g]), 32'(e[15:0]));
                    last_data[g] = e[15:0];
                end else begin
                    if (valid_s[g]) check("valid_unexpected", g, 32'(valid_s[g]), 32'd0);
                    check("data_hold", g, 32'(data_s[g]), 32'(last_data[g]));
                end
            end
        end
    end

endmodule
